// File: rtl/orb_pkg.sv
// orb_pkg: shared definitions for the 3x3 window generator.
//   DW_DEFAULT   default pixel bit width
//   state_t      window generator FSM states
//   K_*          element index of each window position, k = 3*row + col
//                (row 0 = oldest line, col 0 = oldest column)
package orb_pkg;

    localparam int unsigned DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned K_TL     = 0;
    localparam int unsigned K_TC     = 1;
    localparam int unsigned K_TR     = 2;
    localparam int unsigned K_ML     = 3;
    localparam int unsigned K_CENTRE = 4;
    localparam int unsigned K_MR     = 5;
    localparam int unsigned K_BL     = 6;
    localparam int unsigned K_BC     = 7;
    localparam int unsigned K_BR     = 8;
    localparam int unsigned N_TAPS   = 9;

endpackage

// File: rtl/row_delay.sv
// row_delay: WIDTH-deep pixel delay line, advancing only when en is high.
// dout presents the pixel accepted WIDTH enabled cycles earlier.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears every tap)
//   en     shift enable
//   din    pixel in
//   dout   delayed pixel out
module row_delay #(
    parameter int unsigned WIDTH = 678,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] taps [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                taps[i] <= '0;
            end
        end else if (en) begin
            taps[0] <= din;
            for (int unsigned i = 1; i < WIDTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[WIDTH-1];

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster-order 3x3 sliding window generator.
//   clk, rst_n   clock / asynchronous active-low reset
//   sof          start of frame, qualified by din_valid
//   din          pixel, din_valid accept strobe
//   win          9*DW window, element k=3*r+c at [DW*k +: DW]
//   win_valid    win / win_x / win_y valid (one cycle after the pixel)
//   win_x, win_y window centre coordinates
//   frame_done   one-cycle pulse after the last pixel of a frame
//   busy         FSM not in IDLE
//   frame_cnt    completed frame count (only with WINGEN_FRAME_CNT_EN)
// Optional feature macro: WINGEN_FRAME_CNT_EN.
module window_gen_3x3
    import orb_pkg::*;
#(
    parameter int unsigned WIDTH  = 678,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned DW     = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sof,
    input  logic [DW-1:0]   din,
    input  logic            din_valid,
    output logic [9*DW-1:0] win,
    output logic            win_valid,
    output logic [9:0]      win_x,
    output logic [9:0]      win_y,
    output logic            frame_done,
    output logic            busy
`ifdef WINGEN_FRAME_CNT_EN
    ,
    output logic [15:0]     frame_cnt
`endif
);

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);

    state_t        state, state_next;
    logic [9:0]    x_cnt, y_cnt;
    logic [9:0]    px, py;
    logic          accept;
    logic          win_hit;
    logic [DW-1:0] rd1_out, rd2_out;
    logic [DW-1:0] sr      [N_TAPS];
    logic [DW-1:0] sr_next [N_TAPS];

    // An accepted sof pixel is always (0,0), whatever the counters hold.
    always_comb begin
        accept  = din_valid && ((state == ST_FILL) || (state == ST_RUN) ||
                                ((state == ST_IDLE) && sof));
        px      = sof ? '0 : x_cnt;
        py      = sof ? '0 : y_cnt;
        win_hit = accept && (px >= 10'd2) && (py >= 10'd2);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_FILL;
            end
            ST_FILL, ST_RUN: begin
                if (accept) begin
                    if (sof) begin
                        state_next = ST_FILL;
                    end else if ((px == X_LAST) && (py == Y_LAST)) begin
                        state_next = ST_DONE;
                    end else if ((state == ST_FILL) && (px == 10'd2) && (py == 10'd2)) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_DONE);
    end

    // Position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (state == ST_DONE) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (accept) begin
            if (px == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= py + 10'd1;
            end else begin
                x_cnt <= px + 10'd1;
                y_cnt <= py;
            end
        end
    end

    // Line buffers: rd1 holds the previous line, rd2 the one before it.
    row_delay #(.WIDTH(WIDTH), .DW(DW)) u_row_delay_1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .din   (din),
        .dout  (rd1_out)
    );

    row_delay #(.WIDTH(WIDTH), .DW(DW)) u_row_delay_2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .din   (rd1_out),
        .dout  (rd2_out)
    );

    // Column shift: each row slides left, the newest column enters on the right.
    always_comb begin
        sr_next[K_TL]     = sr[K_TC];
        sr_next[K_TC]     = sr[K_TR];
        sr_next[K_TR]     = rd2_out;
        sr_next[K_ML]     = sr[K_CENTRE];
        sr_next[K_CENTRE] = sr[K_MR];
        sr_next[K_MR]     = rd1_out;
        sr_next[K_BL]     = sr[K_BC];
        sr_next[K_BC]     = sr[K_BR];
        sr_next[K_BR]     = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_TAPS; k++) begin
                sr[k] <= '0;
            end
        end else if (accept) begin
            for (int unsigned k = 0; k < N_TAPS; k++) begin
                sr[k] <= sr_next[k];
            end
        end
    end

    // Window output registers hold their contents between valid windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win       <= '0;
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
        end else begin
            win_valid <= win_hit;
            if (win_hit) begin
                win_x <= px - 10'd1;
                win_y <= py - 10'd1;
                for (int unsigned k = 0; k < N_TAPS; k++) begin
                    win[DW*k +: DW] <= sr_next[k];
                end
            end
        end
    end

`ifdef WINGEN_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (state == ST_DONE) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct packed {
        logic [9:0]  cx;
        logic [9:0]  cy;
        logic [71:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sof;
    logic [7:0]  din;
    logic        din_valid;
    logic [71:0] win;
    logic        win_valid;
    logic [9:0]  win_x, win_y;
    logic        frame_done;
    logic        busy;
`ifdef WINGEN_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] exp_cnt;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_win    = 0;
    exp_t q[$];
    exp_t last_e;
    bit   in_frame;

    window_gen_3x3 #(.WIDTH(W), .HEIGHT(H), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sof        (sof),
        .din        (din),
        .din_valid  (din_valid),
        .win        (win),
        .win_valid  (win_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef WINGEN_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int x, input int y);
        return 8'(16 * y + x);
    endfunction

    // One clock: drive inputs, predict, then check outputs 1 time unit after the edge.
    task automatic cyc(input logic v, input logic s, input int x, input int y);
        bit   acc, exp_win, done_now;
        exp_t e;
        din_valid = v;
        sof       = s;
        din       = pix(x, y);
        acc       = v && (s || in_frame);
        exp_win   = acc && (x >= 2) && (y >= 2);
        done_now  = 1'b0;
        if (exp_win) begin
            e.cx = 10'(x - 1);
            e.cy = 10'(y - 1);
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.w[8*(3*r+c) +: 8] = pix(x - 2 + c, y - 2 + r);
            q.push_back(e);
        end
        if (acc) begin
            in_frame = 1'b1;
            if (x == W-1 && y == H-1) begin
                in_frame = 1'b0;
                done_now = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sof       = 1'b0;
        n_checks++;
        if (exp_win) begin
            e = q.pop_front();
            if (win_valid !== 1'b1 || win_x !== e.cx || win_y !== e.cy || win !== e.w) begin
                n_fail++;
                $display("FAIL window: got valid=%b x=%0d y=%0d win=%h, want valid=1 x=%0d y=%0d win=%h",
                         win_valid, win_x, win_y, win, e.cx, e.cy, e.w);
            end
            last_e = e;
            n_win++;
        end else begin
            if (win_valid !== 1'b0 || win_x !== last_e.cx || win_y !== last_e.cy || win !== last_e.w) begin
                n_fail++;
                $display("FAIL hold: got valid=%b x=%0d y=%0d win=%h, want valid=0 x=%0d y=%0d win=%h",
                         win_valid, win_x, win_y, win, last_e.cx, last_e.cy, last_e.w);
            end
        end
        n_checks++;
        if (frame_done !== done_now) begin
            n_fail++;
            $display("FAIL frame_done: got %b want %b", frame_done, done_now);
        end
        n_checks++;
        if (busy !== (in_frame || done_now)) begin
            n_fail++;
            $display("FAIL busy: got %b want %b", busy, (in_frame || done_now));
        end
`ifdef WINGEN_FRAME_CNT_EN
        n_checks++;
        if (frame_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, exp_cnt);
        end
        if (done_now) exp_cnt++;
`endif
    endtask

    task automatic send_frame(input bit gaps);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                cyc(1'b1, (x == 0 && y == 0), x, y);
                if (gaps) cyc(1'b0, 1'b0, x, y);
            end
        cyc(1'b0, 1'b0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if (win !== '0 || win_valid !== 1'b0 || win_x !== '0 || win_y !== '0 ||
            frame_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got win=%h valid=%b x=%0d y=%0d done=%b busy=%b, want all 0",
                     tag, win, win_valid, win_x, win_y, frame_done, busy);
        end
`ifdef WINGEN_FRAME_CNT_EN
        n_checks++;
        if (frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL %s_frame_cnt: got %0d want 0", tag, frame_cnt);
        end
`endif
    endtask

    task automatic model_reset();
        q.delete();
        in_frame = 1'b0;
        last_e   = '0;
`ifdef WINGEN_FRAME_CNT_EN
        exp_cnt  = '0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sof = 1'b0; din = '0; din_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 3, 3);   // no sof: ignored in IDLE
        cyc(1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_continuous();
        n_win = 0;
        send_frame(1'b0);
        n_checks++;
        if (n_win != (W-2)*(H-2)) begin
            n_fail++;
            $display("FAIL window_count_cont: got %0d want %0d", n_win, (W-2)*(H-2));
        end
    endtask

    task automatic test_gaps();
        n_win = 0;
        send_frame(1'b1);
        n_checks++;
        if (n_win != (W-2)*(H-2)) begin
            n_fail++;
            $display("FAIL window_count_gaps: got %0d want %0d", n_win, (W-2)*(H-2));
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < W*3 + 3; i++)
            cyc(1'b1, (i == 0), i % W, i / W);
        n_win = 0;
        send_frame(1'b0);    // sof at what would be (3,3)
        n_checks++;
        if (n_win != (W-2)*(H-2)) begin
            n_fail++;
            $display("FAIL window_count_abort: got %0d want %0d", n_win, (W-2)*(H-2));
        end
    endtask

    task automatic test_col_boundary();
        for (int i = 0; i < W*3 + 2; i++) begin
            cyc(1'b1, (i == 0), i % W, i / W);
            if (i == W*2 + 7) begin
                n_checks++;
                if (win_valid !== 1'b1 || win_x !== 10'd6 || win_y !== 10'd1) begin
                    n_fail++;
                    $display("FAIL col_edge_72: got valid=%b x=%0d y=%0d want 1 6 1",
                             win_valid, win_x, win_y);
                end
            end
            if (i >= W*3) begin
                n_checks++;
                if (win_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL col_wrap: got valid=%b want 0 at x=%0d", win_valid, i % W);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < W*2 + 4; i++)
            cyc(1'b1, (i == 0), i % W, i / W);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = W*2 + 4; i < W*4; i++)
            cyc(1'b1, 1'b0, i % W, i / W);
        cyc(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_abort();
        test_col_boundary();
        test_reset_mid();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter WIDTH, default 678: pixels per line, including the border extension.
REQ-002 SHALL have parameter HEIGHT, default 480: lines per frame.
REQ-003 SHALL have parameter DW, default 8: pixel bit width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sof  input  1  start-of-frame, sampled only together with din_valid.
REQ-007 SHALL have port din  input  DW  pixel, raster order.
REQ-008 SHALL have port din_valid  input  1  pixel accept strobe (en).
REQ-009 SHALL have port win  output  9*DW  3x3 window; element k=3*r+c sits at bits [DW*k+DW-1:DW*k]; r=0 is the oldest row, c=0 the oldest column.
REQ-010 SHALL have port win_valid  output  1  win, win_x and win_y valid this cycle.
REQ-011 SHALL have port win_x  output  10  window centre column.
REQ-012 SHALL have port win_y  output  10  window centre row.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL run an FSM with states IDLE, FILL, RUN and DONE.
REQ-016 IDLE: din_valid&&sof SHALL take the pixel as (0,0) and go to FILL; din_valid without sof SHALL be ignored.
REQ-017 FILL: SHALL accept pixels and go to RUN on acceptance of pixel (x=2, y=2).
REQ-018 RUN: SHALL go to DONE on acceptance of pixel (WIDTH-1, HEIGHT-1).
REQ-019 DONE: SHALL last one cycle, pulse frame_done and return to IDLE; din_valid in DONE SHALL be ignored.
REQ-020 SHALL keep a column counter 0..WIDTH-1 that wraps to 0 and increments the row counter; both advance only on accepted pixels.
REQ-021 din_valid&&sof in FILL or RUN SHALL abort the current frame, take the pixel as (0,0) and enter FILL; frame_done SHALL NOT pulse.
REQ-022 SHALL hold two internal row delays of WIDTH pixels each plus a 3x3 column shift register; all advance only on accepted pixels.
REQ-023 Latency: the cycle after accepting pixel (x,y) with x>=2 and y>=2, win_valid SHALL be 1, win_x=x-1 and win_y=y-1.
REQ-024 SHALL emit no windows for border centres (column 0, column WIDTH-1, row 0, row HEIGHT-1): exactly (WIDTH-2)*(HEIGHT-2) windows per frame.
REQ-025 win_valid SHALL be 0 in any cycle not covered by REQ-023; win, win_x and win_y SHALL hold their last values when win_valid is 0.
REQ-026 din_valid gaps of any length SHALL stall the block without loss or duplication.
REQ-027 A window whose columns span a line wrap (x<2) SHALL never be emitted.

Reset
REQ-028 rst_n low SHALL act asynchronously and force: state IDLE, counters 0, row delays and shift register 0, win 0, win_valid 0, win_x 0, win_y 0, frame_done 0, busy 0.
REQ-029 Reset mid-frame SHALL discard the frame; the first output after release SHALL be for a new frame starting with sof.

Configuration
REQ-030 With WINGEN_FRAME_CNT_EN defined, SHALL add port frame_cnt  output  16  count of completed frames; it increments with each frame_done, wraps at 0xFFFF->0, resets to 0, and is not incremented by aborted frames.
REQ-031 Without WINGEN_FRAME_CNT_EN, port frame_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package orb_pkg SHALL hold the DW default, the FSM state encodings and the window index constants (K_TL=0 .. K_BR=8, K_CENTRE=4).
REQ-033 SHALL instantiate sub-module row_delay (parameters WIDTH and DW, enable-gated, async reset) twice.

Verification
REQ-034 WIDTH=8, HEIGHT=6, pixel value = 16*y + x, continuous din_valid -> 24 windows; first has win_x=1, win_y=1, elements k0..k8 = 00,01,02,10,11,12,20,21,22 hex, one cycle after pixel 0x22 is accepted.
REQ-035 Same frame with din_valid toggled 1/0 each cycle -> identical window sequence; win_valid never on two consecutive cycles.
REQ-036 Last pixel (7,5) accepted -> final window centre (6,4), then frame_done=1 for one cycle, busy=0 the next cycle; frame_cnt=1 when WINGEN_FRAME_CNT_EN is defined.
REQ-037 sof reasserted at pixel (3,3) -> no frame_done, counters restart, next window centre (1,1) after pixel (2,2) of the new frame; frame_cnt unchanged.
REQ-038 rst_n pulsed low mid-frame at (4,2) -> all outputs 0 immediately; din_valid without sof afterwards -> no windows and busy=0.
REQ-039 Column-boundary check: pixels (7,2) and (0,3) -> win_valid only after (7,2) (centre (6,1)) and none after (0,3) or (1,3).
